// File: rtl/mem_bus_ctl.sv
// mem_bus_ctl: physical-side memory bus controller.
// Arbitrates between a fetch port (i_*) and a data port (d_*). Data requests
// win. Each 16-bit access runs as one or two byte cycles on an external
// 8-bit asynchronous SRAM bus: SETUP, STROBE (with wait states, ready and
// timeout), then HOLD. MMU faults and empty byte enables finish through a
// one-cycle ERR state with no bus activity.
// Ports:
//   clk, reset (async, active low)
//   i_req/i_addr/i_fault -> i_ack/i_err/i_rdata   fetch port (full words)
//   d_req/d_write/d_be/d_addr/d_fault/d_wdata -> d_ack/d_err/d_rdata
//   ext_a/ext_d_out/ext_d_oe/ext_d_in/ext_ce_n/ext_oe_n/ext_we_n/ext_ready
// All outputs are registered.
module mem_bus_ctl #(
    parameter int PA          = 16,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [PA-1:1] i_addr,
    input  logic          i_fault,
    output logic          i_ack,
    output logic          i_err,
    output logic [15:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_write,
    input  logic [1:0]    d_be,
    input  logic [PA-1:1] d_addr,
    input  logic          d_fault,
    input  logic [15:0]   d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [15:0]   d_rdata,
    output logic [PA-1:0] ext_a,
    output logic [7:0]    ext_d_out,
    output logic          ext_d_oe,
    input  logic [7:0]    ext_d_in,
    output logic          ext_ce_n,
    output logic          ext_oe_n,
    output logic          ext_we_n,
    input  logic          ext_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          is_d_q, is_d_d;       // current access belongs to data port
    logic          write_q, write_d;
    logic [PA-1:1] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          lane_q, lane_d;       // byte lane being transferred
    logic          more_q, more_d;       // high byte still to do
    logic [3:0]    wait_q, wait_d;
    logic [7:0]    tout_q, tout_d;
    logic [15:0]   buf_q, buf_d;         // read assembly; unused lanes stay 0
    logic          i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [15:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [PA-1:0] ext_a_q, ext_a_d;
    logic [7:0]    ext_d_out_q, ext_d_out_d;
    logic          ext_d_oe_q, ext_d_oe_d;
    logic          ext_ce_n_q, ext_ce_n_d;
    logic          ext_oe_n_q, ext_oe_n_d;
    logic          ext_we_n_q, ext_we_n_d;

    // Winner selection in IDLE; fetches are always full words.
    logic       sel_d;
    logic [1:0] sel_be;
    logic       sel_fault;
    logic       wait_done;
    logic       ack_d, err_d;
    logic       on_bus_d;

    assign sel_d     = d_req;
    assign sel_be    = d_req ? d_be : 2'b11;
    assign sel_fault = d_req ? d_fault : i_fault;
    assign wait_done = (wait_q == 4'(WAIT_STATES));

    always_comb begin
        state_d     = state_q;
        is_d_d      = is_d_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lane_d      = lane_q;
        more_d      = more_q;
        wait_d      = wait_q;
        tout_d      = tout_q;
        buf_d       = buf_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        ext_a_d     = ext_a_q;
        ext_d_out_d = ext_d_out_q;

        case (state_q)
            S_IDLE: begin
                if (d_req || i_req) begin
                    is_d_d  = sel_d;
                    write_d = sel_d & d_write;
                    addr_d  = sel_d ? d_addr : i_addr;
                    wdata_d = sel_d ? d_wdata : 16'h0000;
                    buf_d   = 16'h0000;
                    lane_d  = (sel_be == 2'b10);
                    more_d  = (sel_be == 2'b11);
                    if (sel_fault) begin
                        state_d = S_ERR;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else if (sel_be == 2'b00) begin
                        state_d = S_ERR;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = S_STROBE;
            S_STROBE: begin
                if (!wait_done) begin
                    wait_d = wait_q + 4'd1;
                end else if (ext_ready) begin
                    if (!write_q) begin
                        if (lane_q) buf_d[15:8] = ext_d_in;
                        else        buf_d[7:0]  = ext_d_in;
                    end
                    state_d = S_HOLD;
                    // Ack rides in the final HOLD cycle.
                    ack_d   = !more_q;
                end else if (tout_q == 8'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tout_d = tout_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (more_q) begin
                    lane_d  = 1'b1;
                    more_d  = 1'b0;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Address and write byte only move when a new byte enters SETUP,
        // i.e. while all strobes are high.
        if (state_d == S_SETUP) begin
            wait_d      = 4'd0;
            tout_d      = 8'd0;
            ext_a_d     = {addr_d, lane_d};
            ext_d_out_d = write_d ? (lane_d ? wdata_d[15:8] : wdata_d[7:0]) : 8'h00;
        end

        if (ack_d) begin
            if (is_d_d) d_rdata_d = buf_d;
            else        i_rdata_d = buf_d;
        end
    end

    assign on_bus_d   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    assign i_ack_d    = ack_d & !is_d_d;
    assign i_err_d    = err_d & !is_d_d;
    assign d_ack_d    = ack_d & is_d_d;
    assign d_err_d    = err_d & is_d_d;
    assign ext_ce_n_d = !on_bus_d;
    assign ext_oe_n_d = !((state_d == S_STROBE) && !write_d);
    assign ext_we_n_d = !((state_d == S_STROBE) && write_d);
    assign ext_d_oe_d = on_bus_d && write_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            is_d_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            lane_q      <= 1'b0;
            more_q      <= 1'b0;
            wait_q      <= 4'd0;
            tout_q      <= 8'd0;
            buf_q       <= 16'h0000;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= 16'h0000;
            d_rdata_q   <= 16'h0000;
            ext_a_q     <= '0;
            ext_d_out_q <= 8'h00;
            ext_d_oe_q  <= 1'b0;
            ext_ce_n_q  <= 1'b1;
            ext_oe_n_q  <= 1'b1;
            ext_we_n_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            is_d_q      <= is_d_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lane_q      <= lane_d;
            more_q      <= more_d;
            wait_q      <= wait_d;
            tout_q      <= tout_d;
            buf_q       <= buf_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            ext_a_q     <= ext_a_d;
            ext_d_out_q <= ext_d_out_d;
            ext_d_oe_q  <= ext_d_oe_d;
            ext_ce_n_q  <= ext_ce_n_d;
            ext_oe_n_q  <= ext_oe_n_d;
            ext_we_n_q  <= ext_we_n_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign ext_a     = ext_a_q;
    assign ext_d_out = ext_d_out_q;
    assign ext_d_oe  = ext_d_oe_q;
    assign ext_ce_n  = ext_ce_n_q;
    assign ext_oe_n  = ext_oe_n_q;
    assign ext_we_n  = ext_we_n_q;

endmodule

// File: tb/tb_mem_bus_ctl.sv
// Testbench for mem_bus_ctl: SRAM byte model, scoreboard of expected
// completions (port, cycle, err, data) popped on every ack, plus bus
// activity counters sampled on the falling clock edge.
module tb_mem_bus_ctl;

    localparam int PA = 16;
    localparam int WS = 1;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0, i_fault = 1'b0;
    logic [PA-1:1] i_addr = '0;
    logic          i_ack, i_err;
    logic [15:0]   i_rdata;
    logic          d_req = 1'b0, d_write = 1'b0, d_fault = 1'b0;
    logic [1:0]    d_be = 2'b11;
    logic [PA-1:1] d_addr = '0;
    logic [15:0]   d_wdata = 16'h0000;
    logic          d_ack, d_err;
    logic [15:0]   d_rdata;
    logic [PA-1:0] ext_a;
    logic [7:0]    ext_d_out, ext_d_in;
    logic          ext_d_oe, ext_ce_n, ext_oe_n, ext_we_n;
    logic          ext_ready = 1'b1;

    mem_bus_ctl #(.PA(PA), .WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_fault(i_fault),
        .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_be(d_be), .d_addr(d_addr),
        .d_fault(d_fault), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .ext_a(ext_a), .ext_d_out(ext_d_out), .ext_d_oe(ext_d_oe),
        .ext_d_in(ext_d_in), .ext_ce_n(ext_ce_n), .ext_oe_n(ext_oe_n),
        .ext_we_n(ext_we_n), .ext_ready(ext_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: preload once, then write on every cycle we_n is low.
    logic [7:0] mem [0:65535];
    assign ext_d_in = mem[ext_a];
    always @(posedge clk) begin
        if (cyc == 0) begin
            mem[16'h2468] <= 8'hCD;
            mem[16'h2469] <= 8'hAB;
            mem[16'h0200] <= 8'h34;
            mem[16'h0201] <= 8'h12;
        end else if (rst_n && !ext_we_n) begin
            mem[ext_a] <= ext_d_out;
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          err;
        bit          chk_data;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: scoreboard pops, bus activity counters, protocol violations.
    int oe_low = 0, oe_pulses = 0, we_low = 0, ce_low = 0;
    int viol = 0, dual = 0;
    logic [PA-1:0] we_a = '0;
    logic [7:0]    we_dout = '0;
    logic          prev_strb = 1'b0;
    logic [PA-1:0] prev_a = '0;
    logic [7:0]    prev_dout = '0;
    logic          prev_oe_n = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strb <= 1'b0;
            prev_oe_n <= 1'b1;
        end else begin
            if (i_ack && d_ack) dual <= dual + 1;
            if (i_ack || d_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_port", {31'd0, d_ack}, {31'd0, e.is_d});
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_err", {31'd0, d_ack ? d_err : i_err}, {31'd0, e.err});
                    if (e.chk_data)
                        chk("rdata", {16'd0, d_ack ? d_rdata : i_rdata}, {16'd0, e.rdata});
                end
            end
            if (!ext_oe_n) oe_low <= oe_low + 1;
            if (!ext_oe_n && prev_oe_n) oe_pulses <= oe_pulses + 1;
            if (!ext_ce_n) ce_low <= ce_low + 1;
            if (!ext_we_n) begin
                we_low  <= we_low + 1;
                we_a    <= ext_a;
                we_dout <= ext_d_out;
                if (!ext_d_oe) viol <= viol + 1;
            end
            if ((!ext_oe_n || !ext_we_n) && prev_strb &&
                (ext_a != prev_a || ext_d_out != prev_dout)) viol <= viol + 1;
            prev_strb <= !ext_oe_n || !ext_we_n;
            prev_a    <= ext_a;
            prev_dout <= ext_d_out;
            prev_oe_n <= ext_oe_n;
        end
    end

    task automatic wait_ack(input bit is_d, input string tag);
        bit got = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (is_d ? d_ack : i_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(tag, 0, 1);
    endtask

    task automatic do_d(input bit wr, input logic [1:0] be, input logic [15:0] addr,
                        input logic [15:0] wd, input bit flt, input bit exp_err,
                        input bit cd, input logic [15:0] exp_rd, input int lat);
        exp_t e;
        @(posedge clk); #1;
        d_req = 1; d_write = wr; d_be = be; d_addr = addr[14:0];
        d_wdata = wd; d_fault = flt;
        e.is_d = 1; e.err = exp_err; e.chk_data = cd; e.rdata = exp_rd; e.cyc = cyc + lat;
        exp_q.push_back(e);
        wait_ack(1, "d_ack_timeout");
        @(posedge clk); #1;
        d_req = 0; d_fault = 0;
    endtask

    int s_oe, s_pul, s_we, s_ce;
    task automatic snap();
        s_oe = oe_low; s_pul = oe_pulses; s_we = we_low; s_ce = ce_low;
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        chk("rst_ce_n", {31'd0, ext_ce_n}, 1);
        chk("rst_oe_n", {31'd0, ext_oe_n}, 1);
        chk("rst_we_n", {31'd0, ext_we_n}, 1);
        chk("rst_d_oe", {31'd0, ext_d_oe}, 0);
        chk("rst_ext_a", {16'd0, ext_a}, 0);
        chk("rst_acks", {28'd0, i_ack, d_ack, i_err, d_err}, 0);
        @(posedge clk); #1 rst_n = 1;

        // Word read: two 2-cycle oe pulses, ack in cycle 8.
        snap();
        do_d(0, 2'b11, 16'h1234, 16'h0, 0, 0, 1, 16'hABCD, 8);
        chk("wr_rd_oe_cycles", oe_low - s_oe, 4);
        chk("wr_rd_oe_pulses", oe_pulses - s_pul, 2);

        // High-byte write at 0x0010 -> byte 0x0021.
        snap();
        do_d(1, 2'b10, 16'h0010, 16'h5A00, 0, 0, 0, 16'h0, 4);
        chk("bw_we_cycles", we_low - s_we, 2);
        chk("bw_ext_a", {16'd0, we_a}, 32'h21);
        chk("bw_dout", {24'd0, we_dout}, 32'h5A);
        chk("bw_mem_hi", {24'd0, mem[16'h0021]}, 32'h5A);
        chk("bw_mem_lo", {24'd0, mem[16'h0020]}, 0);
        // Read it back as a high byte, and a low byte elsewhere: dead lane is 0.
        do_d(0, 2'b10, 16'h0010, 16'h0, 0, 0, 1, 16'h5A00, 4);
        do_d(0, 2'b01, 16'h1234, 16'h0, 0, 0, 1, 16'h00CD, 4);

        // Word write then read back.
        do_d(1, 2'b11, 16'h0300, 16'hBEEF, 0, 0, 0, 16'h0, 8);
        do_d(0, 2'b11, 16'h0300, 16'h0, 0, 0, 1, 16'hBEEF, 8);

        // Fault and empty byte enables: ack in cycle 1, no bus.
        snap();
        do_d(0, 2'b11, 16'h1234, 16'h0, 1, 1, 0, 16'h0, 1);
        do_d(1, 2'b00, 16'h1234, 16'h0, 0, 0, 0, 16'h0, 1);
        chk("flt_ce_cycles", ce_low - s_ce, 0);

        // Fetch fault.
        @(posedge clk); #1;
        i_req = 1; i_addr = 15'h0100; i_fault = 1;
        e = '{is_d: 0, err: 1, chk_data: 0, rdata: 16'h0, cyc: cyc + 1};
        exp_q.push_back(e);
        wait_ack(0, "i_ack_timeout");
        @(posedge clk); #1 i_req = 0; i_fault = 0;

        // Simultaneous requests: data first, fetch right after with no gap.
        @(posedge clk); #1;
        d_req = 1; d_write = 0; d_be = 2'b11; d_addr = 15'h1234;
        i_req = 1; i_addr = 15'h0100;
        e = '{is_d: 1, err: 0, chk_data: 1, rdata: 16'hABCD, cyc: cyc + 8};
        exp_q.push_back(e);
        e = '{is_d: 0, err: 0, chk_data: 1, rdata: 16'h1234, cyc: cyc + 17};
        exp_q.push_back(e);
        wait_ack(1, "d_ack_timeout");
        @(posedge clk); #1 d_req = 0;
        wait_ack(0, "i_ack_timeout");
        @(posedge clk); #1 i_req = 0;

        // Timeout: strobe low WS+TO cycles, then ERR ack in cycle 7.
        ext_ready = 0;
        snap();
        do_d(0, 2'b11, 16'h1234, 16'h0, 0, 1, 0, 16'h0, 7);
        chk("to_oe_cycles", oe_low - s_oe, WS + TO);
        chk("to_ce_cycles", ce_low - s_ce, WS + TO + 1);
        chk("to_oe_n_after", {31'd0, ext_oe_n}, 1);
        ext_ready = 1;

        // Reset during write strobe: immediate release, no ack afterwards.
        @(posedge clk); #1;
        d_req = 1; d_write = 1; d_be = 2'b11; d_addr = 15'h0400; d_wdata = 16'h1357;
        begin
            bit seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!ext_we_n) begin seen = 1; break; end
            end
            chk("rs_we_seen", {31'd0, seen}, 1);
        end
        #1 rst_n = 0;
        #1;
        chk("rs_we_n", {31'd0, ext_we_n}, 1);
        chk("rs_ce_n", {31'd0, ext_ce_n}, 1);
        chk("rs_d_oe", {31'd0, ext_d_oe}, 0);
        chk("rs_ext_a", {16'd0, ext_a}, 0);
        d_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (12) @(posedge clk);
        do_d(0, 2'b11, 16'h1234, 16'h0, 0, 0, 1, 16'hABCD, 8);

        repeat (3) @(posedge clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("bus_viol", viol, 0);
        chk("dual_ack", dual, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_ctl.md
# mem_bus_ctl

Physical-side memory bus controller sitting directly downstream of the MMU. It takes the translated instruction-fetch address and data address, plus each side's fault flag, and arbitrates between them. It runs 16-bit accesses as one or two byte cycles on an external 8-bit asynchronous SRAM-style bus, with programmable wait states, a ready input and a timeout. Results go back to the core on separate fetch and data ports using a level-request / single-cycle-acknowledge handshake.

## Interface

Parameters:

- PA, 16: physical address width in bytes. Word address inputs are PA-1:1.
- WAIT_STATES, 1: minimum extra STROBE cycles per byte, 0..15.
- TIMEOUT, 255: STROBE cycles allowed with ext_ready low before abort, 1..255.

Ports:

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  PA-1:1  translated fetch word address (MMU pcp).
- i_fault  in  1  MMU miss fault for the fetch.
- i_ack  out  1  one-cycle fetch completion.
- i_err  out  1  valid with i_ack: fault or timeout.
- i_rdata  out  16  fetched word; valid with i_ack.
- d_req  in  1  data request; held until d_ack.
- d_write  in  1  1 = write.
- d_be  in  2  byte enables: 11 word, 01 low byte, 10 high byte.
- d_addr  in  PA-1:1  translated data word address (MMU addrp).
- d_fault  in  1  MMU miss or protection fault for the data access.
- d_wdata  in  16  write data.
- d_ack  out  1  one-cycle data completion.
- d_err  out  1  valid with d_ack.
- d_rdata  out  16  read data; disabled lane reads 0.
- ext_a  out  PA  byte address.
- ext_d_out  out  8  write byte.
- ext_d_oe  out  1  data pad output enable.
- ext_d_in  in  8  read byte.
- ext_ce_n, ext_oe_n, ext_we_n  out  1 each  active-low strobes.
- ext_ready  in  1  device ready; 1 = done.

## Operation

- States: IDLE, SETUP, STROBE, HOLD, ERR.
- IDLE arbitration:
  - d_req wins over i_req.
  - The winner's address, be, write flag and wdata are latched. Requesters must hold these stable until ack regardless.
  - Fetches are always full words.
- Fault short-circuit:
  - If the winner's fault input is high in IDLE, go to ERR with no bus activity.
  - ERR lasts one cycle: matching ack=1, err=1, then IDLE.
- d_be=00: go to ERR with ack=1, err=0 and no bus cycle.
- Byte sequencing:
  - Word access: low byte (ext_a={addr,0}) first, then high byte ({addr,1}).
  - Single-byte access: one cycle at {addr,be[1]}.
- SETUP (1 cycle): ce_n=0, ext_a valid. For writes, ext_d_oe=1 and ext_d_out is the lane byte.
- STROBE:
  - oe_n=0 for reads, we_n=0 for writes.
  - The wait counter counts WAIT_STATES cycles.
  - On each STROBE cycle after that, if ext_ready=1: a read captures ext_d_in into its lane and the state goes to HOLD.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT, drop strobes and ce, go to ERR (ack=1, err=1); the read data is undefined.
- HOLD (1 cycle):
  - Strobes are high; ce_n, ext_a and write data are still held.
  - If another byte remains, go to SETUP.
  - Otherwise assert the ack (err=0) and go to IDLE.
- Both counters clear on every SETUP.
- Reset values (immediate, asynchronous): state IDLE; ext_ce_n=ext_oe_n=ext_we_n=1; ext_d_oe=0; ext_a=0; ext_d_out=0; acks, errs and rdata=0.
- Reset asserted mid-cycle aborts the access with no ack.

## Timing

- Cycle 0 is IDLE with req high. Per byte: SETUP 1 cycle, STROBE ≥ WAIT_STATES+1 cycles, HOLD 1 cycle.
- Ack cycle with ext_ready=1:
  - Word: cycle 2·(WAIT_STATES+3). With WAIT_STATES=1, ack is in cycle 8.
  - Byte: cycle WAIT_STATES+3.
  - Fault: cycle 1.
- The requester samples ack at the edge ending the ack cycle and drops or changes req before the next cycle.
- Because the controller is in IDLE that cycle, back-to-back requests start with no gap.
- ext_a and ext_d_out never change while any strobe is low.
- ext_d_oe is high from SETUP through HOLD of write bytes only.
- Each ack and err is high for exactly one cycle. i_ack and d_ack are never high together.

## Test plan

- Word read, WAIT_STATES=1, d_addr=0x1234 (bytes 0x2468/0x2469 return 0xCD, 0xAB) -> d_rdata=0xABCD, d_ack in cycle 8, err=0, two oe_n pulses of 2 cycles each.
- Byte write, d_be=10, d_addr=0x0010, d_wdata=0x5A00 -> single cycle at ext_a=0x0021, ext_d_out=0x5A, we_n low 2 cycles, d_ack in cycle 4.
- i_req and d_req together in IDLE -> data access runs first; fetch starts the cycle after d_ack; i_ack 8 cycles later.
- d_req with d_fault=1 -> d_ack=d_err=1 in cycle 1; ce_n stays high throughout.
- ext_ready held low, TIMEOUT=4 -> strobe low WAIT_STATES+4 cycles then released; d_err=1 with d_ack.
- reset pulsed low during STROBE of a word write -> all strobes high and ext_d_oe=0 immediately; no ack after release; the next request completes normally.
